// File: rtl/render_sched_if.sv
// Bus bundle between the metaball render scheduler and its surroundings.
// The master modport is the scheduler side; the slave modport is the balls/framebuffer side.
interface render_sched_if #(
   parameter int N_BALLS = 2
);
   logic                   frame_go;
   logic [N_BALLS-1:0]     mb_vld;
   logic [32*N_BALLS-1:0]  mb_out;
   logic                   px_stb;
   logic [31:0]            p_x;
   logic [31:0]            p_y;
   logic                   w_en_top;
   logic                   w_en_btm;
   logic [9:0]             w_addr;
   logic [11:0]            din;
   logic                   swap_en;
   logic                   busy;
   logic [15:0]            ovr_cnt;

   modport master (
      input  frame_go, mb_vld, mb_out,
      output px_stb, p_x, p_y, w_en_top, w_en_btm, w_addr, din, swap_en, busy, ovr_cnt
   );

   modport slave (
      output frame_go, mb_vld, mb_out,
      input  px_stb, p_x, p_y, w_en_top, w_en_btm, w_addr, din, swap_en, busy, ovr_cnt
   );
endinterface

// File: rtl/render_sched.sv
// Metaball frame scheduler: walks every pixel, collects per-ball field values, writes lit/unlit to a bank.
// Define RENDER_SCHED_OVR_CNT_EN to count frame_go pulses dropped while a frame is in progress.
module render_sched #(
   parameter int          N_BALLS = 2,
   parameter int          COLS    = 32,
   parameter int          ROWS    = 64,
   parameter logic [31:0] STEP    = 32'h0000_8000,
   parameter logic [31:0] THRESH  = 32'h0000_8000
) (
   input  logic           clk,
   input  logic           rst_n,
   render_sched_if.master bus
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [RW-1:0] ROW_HALF = RW'(ROWS / 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_SWAP
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [N_BALLS-1:0]  sticky_q, sticky_d;
   logic [31:0]         val_q [N_BALLS];
   logic [31:0]         val_d [N_BALLS];
   logic [31:0]         fieldSum;
   logic [32:0]         sumExt;
   logic [RW-1:0]       rowInBank;
   logic                inTopBank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         col_q    <= '0;
         row_q    <= '0;
         sticky_q <= '0;
         for (int i = 0; i < N_BALLS; i++) begin
            val_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         sticky_q <= sticky_d;
         for (int i = 0; i < N_BALLS; i++) begin
            val_q[i] <= val_d[i];
         end
      end
   end

   // WAIT leaves on the same edge that sets the last sticky bit, so WRITE follows the final valid pulse.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      sticky_d = sticky_q;
      for (int i = 0; i < N_BALLS; i++) begin
         val_d[i] = val_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.frame_go) begin
               col_d   = '0;
               row_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            sticky_d = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            for (int i = 0; i < N_BALLS; i++) begin
               if (bus.mb_vld[i]) begin
                  sticky_d[i] = 1'b1;
                  val_d[i]    = bus.mb_out[32*i +: 32];
               end
            end
            if (&sticky_d) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (row_q == ROW_LAST) begin
                  row_d   = '0;
                  state_d = ST_SWAP;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = ST_ISSUE;
               end
            end else begin
               col_d   = col_q + 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_SWAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Saturating accumulation keeps a huge field from wrapping around to "unlit".
   always_comb begin
      fieldSum = '0;
      sumExt   = '0;
      for (int i = 0; i < N_BALLS; i++) begin
         sumExt   = {1'b0, fieldSum} + {1'b0, val_q[i]};
         fieldSum = sumExt[32] ? 32'hFFFF_FFFF : sumExt[31:0];
      end
   end

   assign inTopBank = (row_q < ROW_HALF);
   assign rowInBank = inTopBank ? row_q : (row_q - ROW_HALF);

   assign bus.px_stb   = (state_q == ST_ISSUE);
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.swap_en  = (state_q == ST_SWAP);
   assign bus.w_en_top = (state_q == ST_WRITE) && inTopBank;
   assign bus.w_en_btm = (state_q == ST_WRITE) && !inTopBank;
   assign bus.din      = ((state_q == ST_WRITE) && (fieldSum >= THRESH)) ? 12'hFFF : 12'h000;
   assign bus.p_x      = 32'(col_q) * STEP;
   assign bus.p_y      = 32'(row_q) * STEP;
   assign bus.w_addr   = 10'(rowInBank) * 10'(COLS) + 10'(col_q);

`ifdef RENDER_SCHED_OVR_CNT_EN
   logic [15:0] ovrCnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovrCnt_q <= '0;
      end else if (bus.frame_go && (state_q != ST_IDLE) && (ovrCnt_q != 16'hFFFF)) begin
         ovrCnt_q <= ovrCnt_q + 16'd1;
      end
   end

   assign bus.ovr_cnt = ovrCnt_q;
`else
   assign bus.ovr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_render_sched.sv
// Randomized self-checking bench for render_sched: a pixel-level model predicts every write, swap and drop.
// Honors RENDER_SCHED_OVR_CNT_EN the same way as the design when predicting ovr_cnt.
module tb_render_sched;

   localparam int          N_BALLS = 2;
   localparam int          COLS    = 32;
   localparam int          ROWS    = 64;
   localparam int          HALF    = ROWS / 2;
   localparam logic [31:0] STEP    = 32'h0000_8000;
   localparam logic [31:0] THRESH  = 32'h0000_8000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   expOvr = 0;
   bit   aborted = 1'b0;
   int   topWrites = 0;
   int   btmWrites = 0;
   int   swaps = 0;

   render_sched_if #(.N_BALLS(N_BALLS)) bus ();

   render_sched #(
      .N_BALLS(N_BALLS),
      .COLS   (COLS),
      .ROWS   (ROWS),
      .STEP   (STEP),
      .THRESH (THRESH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.w_en_top) topWrites++;
      if (bus.w_en_btm) btmWrites++;
      if (bus.swap_en)  swaps++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Expected pixel colour from the two field values, using wide arithmetic and an explicit clamp.
   function automatic logic [11:0] expDin(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'({32'd0, a}) + longint'({32'd0, b});
      if (s > 64'sh0000_0000_FFFF_FFFF) s = 64'sh0000_0000_FFFF_FFFF;
      return (s >= longint'({32'd0, THRESH})) ? 12'hFFF : 12'h000;
   endfunction

   function automatic logic [31:0] pickValue();
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_0000 | 32'($urandom_range(0, 32'h0000_FFFF));
         1:       return 32'h0000_4000;
         2:       return 32'h0000_3FFF;
         3:       return 32'h0000_0000;
         default: return 32'($urandom_range(0, 32'h0000_6000));
      endcase
   endfunction

   task automatic startFrame();
      @(negedge clk);
      bus.frame_go = 1'b1;
      @(negedge clk);
      bus.frame_go = 1'b0;
   endtask

   // Serves one pixel: fixed (isRand=0) or randomized ball answers, then checks the resulting write.
   task automatic applyStimulus(input int p, input bit isRand, input logic [31:0] fv0, input logic [31:0] fv1,
                                input int fd0, input int fd1, input bit goMid);
      logic [31:0] v [2];
      logic [31:0] jv [2];
      int          d [2];
      int          je [2];
      int          maxd;
      int          big;
      int          row;
      int          col;
      bit          seen;
      bit          stray;
      logic [1:0]  vld;
      logic [63:0] outv;

      row = p / COLS;
      col = p % COLS;
      seen = bus.px_stb;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = bus.px_stb;
      end
      if (!seen) begin
         checkOutput("pxStbTimeout", 32'd0, 32'd1);
         aborted = 1'b1;
         return;
      end
      checkOutput("p_x", bus.p_x, 32'(col) * STEP);
      checkOutput("p_y", bus.p_y, 32'(row) * STEP);

      je[0] = 0;
      je[1] = 0;
      jv[0] = '0;
      jv[1] = '0;
      if (isRand) begin
         for (int i = 0; i < 2; i++) begin
            d[i] = $urandom_range(1, 5);
            v[i] = pickValue();
         end
         big = (d[0] >= d[1]) ? 0 : 1;
         for (int i = 0; i < 2; i++) begin
            if (i != big && d[i] > 1 && $urandom_range(0, 3) == 0) begin
               je[i] = $urandom_range(1, d[i] - 1);
               jv[i] = $urandom;
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            bus.mb_vld = 2'b11;
            bus.mb_out = {$urandom, $urandom};
         end
      end else begin
         v[0] = fv0;
         v[1] = fv1;
         d[0] = fd0;
         d[1] = fd1;
      end
      maxd = (d[0] > d[1]) ? d[0] : d[1];

      stray = 1'b0;
      for (int k = 1; k <= maxd; k++) begin
         @(negedge clk);
         if (k == 1 && bus.px_stb) stray = 1'b1;
         if (bus.w_en_top || bus.w_en_btm) stray = 1'b1;
         bus.frame_go = goMid && (k == 1);
         vld = '0;
         outv = {$urandom, $urandom};
         for (int i = 0; i < 2; i++) begin
            if (k == d[i]) begin
               vld[i] = 1'b1;
               outv[32*i +: 32] = v[i];
            end else if (k == je[i]) begin
               vld[i] = 1'b1;
               outv[32*i +: 32] = jv[i];
            end
         end
         bus.mb_vld = vld;
         bus.mb_out = outv;
      end

      @(negedge clk);
      bus.mb_vld = '0;
      bus.frame_go = 1'b0;
      checkOutput("noEarlyWrite", 32'(stray), 32'd0);
      checkOutput("w_en_top", 32'(bus.w_en_top), 32'(row < HALF));
      checkOutput("w_en_btm", 32'(bus.w_en_btm), 32'(row >= HALF));
      checkOutput("w_addr", 32'(bus.w_addr), 32'(((row % HALF) * COLS + col) % 1024));
      checkOutput("din", 32'(bus.din), 32'(expDin(v[0], v[1])));
   endtask

   // mode 0: every ball answers 0 after one cycle; mode 1: directed head pixels then random.
   task automatic runFrame(input int mode, input bit midGo, input bit swapGo);
      int top0;
      int btm0;
      int sw0;
      bit g;

      top0 = topWrites;
      btm0 = btmWrites;
      sw0 = swaps;
      startFrame();
      for (int p = 0; p < COLS * ROWS && !aborted; p++) begin
         g = midGo && (p == 100 || p == 700 || p == 1500);
         if (mode == 0)   applyStimulus(p, 1'b0, 32'h0, 32'h0, 1, 1, g);
         else if (p == 0) applyStimulus(p, 1'b0, 32'h0000_4000, 32'h0000_4000, 3, 3, g);
         else if (p == 1) applyStimulus(p, 1'b0, 32'h0000_1000, 32'h0000_2000, 1, 5, g);
         else if (p == 2) applyStimulus(p, 1'b0, 32'hFFFF_0000, 32'hFFFF_0000, 2, 2, g);
         else if (p == 3) applyStimulus(p, 1'b0, 32'hFFFF_F000, 32'h0000_2000, 1, 1, g);
         else if (p == 4) applyStimulus(p, 1'b0, 32'h0000_4000, 32'h0000_3FFF, 4, 2, g);
         else             applyStimulus(p, 1'b1, 32'h0, 32'h0, 0, 0, g);
`ifdef RENDER_SCHED_OVR_CNT_EN
         if (g) expOvr++;
`endif
      end
      if (aborted) return;
      checkOutput("ovrMidFrame", 32'(bus.ovr_cnt), 32'(expOvr));

      @(negedge clk);
      checkOutput("swap_en", 32'(bus.swap_en), 32'd1);
      checkOutput("busyInSwap", 32'(bus.busy), 32'd1);
      if (swapGo) begin
         bus.frame_go = 1'b1;
`ifdef RENDER_SCHED_OVR_CNT_EN
         expOvr++;
`endif
      end
      @(negedge clk);
      bus.frame_go = 1'b0;
      checkOutput("swapOneCycle", 32'(bus.swap_en), 32'd0);
      checkOutput("busyAfterSwap", 32'(bus.busy), 32'd0);
      @(negedge clk);
      checkOutput("stayIdle", 32'({bus.busy, bus.px_stb}), 32'd0);
      checkOutput("ovr_cnt", 32'(bus.ovr_cnt), 32'(expOvr));
      checkOutput("topWrites", 32'(topWrites - top0), 32'd1024);
      checkOutput("btmWrites", 32'(btmWrites - btm0), 32'd1024);
      checkOutput("swapCount", 32'(swaps - sw0), 32'd1);
   endtask

   task automatic checkAllZero(input string phase);
      checkOutput({phase, "_busy"},     32'(bus.busy), 32'd0);
      checkOutput({phase, "_px_stb"},   32'(bus.px_stb), 32'd0);
      checkOutput({phase, "_p_x"},      bus.p_x, 32'd0);
      checkOutput({phase, "_p_y"},      bus.p_y, 32'd0);
      checkOutput({phase, "_w_en_top"}, 32'(bus.w_en_top), 32'd0);
      checkOutput({phase, "_w_en_btm"}, 32'(bus.w_en_btm), 32'd0);
      checkOutput({phase, "_w_addr"},   32'(bus.w_addr), 32'd0);
      checkOutput({phase, "_din"},      32'(bus.din), 32'd0);
      checkOutput({phase, "_swap_en"},  32'(bus.swap_en), 32'd0);
      checkOutput({phase, "_ovr_cnt"},  32'(bus.ovr_cnt), 32'd0);
   endtask

   task automatic resetMidFrame();
      int target;
      int sw0;
      bit seen;

      target = 40 * COLS + 5;
      startFrame();
      for (int p = 0; p < target && !aborted; p++) begin
         applyStimulus(p, 1'b0, 32'h0, 32'h0, 1, 1, 1'b0);
      end
      if (aborted) return;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = bus.px_stb;
      end
      if (!seen) begin
         checkOutput("pxStbTimeoutRst", 32'd0, 32'd1);
         aborted = 1'b1;
         return;
      end
      checkOutput("p_xBeforeRst", bus.p_x, 32'(5) * STEP);
      checkOutput("p_yBeforeRst", bus.p_y, 32'(40) * STEP);
      @(negedge clk);
      sw0 = swaps;
      rst_n = 1'b0;
      #1;
      checkAllZero("midRst");
      expOvr = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("noSwapAfterRst", 32'(swaps - sw0), 32'd0);
      checkOutput("idleAfterRst", 32'(bus.busy), 32'd0);
      startFrame();
      checkOutput("restartStb", 32'(bus.px_stb), 32'd1);
      checkOutput("restartPx", bus.p_x, 32'd0);
      checkOutput("restartPy", bus.p_y, 32'd0);
   endtask

   initial begin
      #2_000_000;
      checkOutput("watchdog", 32'd0, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      bus.frame_go = 1'b0;
      bus.mb_vld = '0;
      bus.mb_out = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] frame with directed head pixels and random balls");
      if (!aborted) runFrame(1, 1'b0, 1'b0);
      $display("[TB] zero-field frame with dropped frame_go pulses");
      if (!aborted) runFrame(0, 1'b1, 1'b1);
      $display("[TB] reset in the middle of a frame");
      if (!aborted) resetMidFrame();

      rst_n = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/render_sched.md
RENDER_SCHED -- requirements
Module: render_sched

Interface
REQ-001 SHALL have parameter N_BALLS, default 2: number of metaball units served.
REQ-002 SHALL have parameter COLS, default 32: pixels per row.
REQ-003 SHALL have parameter ROWS, default 64: rows per frame; top bank holds rows 0..ROWS/2-1, bottom bank the rest.
REQ-004 SHALL have parameter STEP, default 32'h0000_8000: Q16.16 coordinate increment per pixel.
REQ-005 SHALL have parameter THRESH, default 32'h0000_8000: field-sum lit threshold.
REQ-006 SHALL have these ports: clk  in  1  system clock; one clock, all logic on rising edge.
REQ-007 SHALL have rst_n  in  1  reset; asynchronous and active-low.
REQ-008 SHALL have frame_go  in  1  single-cycle frame start strobe.
REQ-009 SHALL have mb_vld  in  N_BALLS  per-ball result valid, one-cycle pulses.
REQ-010 SHALL have mb_out  in  32*N_BALLS  per-ball field value, ball i at bits [32i+31:32i].
REQ-011 SHALL have px_stb  out  1  start-pixel strobe to all balls.
REQ-012 SHALL have p_x, p_y  out  32 each  current pixel coordinate, Q16.16.
REQ-013 SHALL have w_en_top, w_en_btm  out  1 each  bank write enables.
REQ-014 SHALL have w_addr  out  10  bank write address; din  out  12  RGB444 write data.
REQ-015 SHALL have swap_en  out  1  buffer swap pulse; busy  out  1  frame in progress.
REQ-016 SHALL have ovr_cnt  out  16  dropped-frame_go count.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT, WRITE, SWAP; busy=1 in every state except IDLE.
REQ-018 IDLE: on frame_go=1 SHALL clear col/row to 0 and go to ISSUE; otherwise stay.
REQ-019 ISSUE: SHALL assert px_stb for exactly this one cycle, clear all sticky-valid bits, go to WAIT.
REQ-020 p_x SHALL equal col*STEP and p_y row*STEP (32-bit, truncated) and SHALL be stable from ISSUE through WRITE.
REQ-021 WAIT: SHALL set sticky bit i and latch mb_out slice i on each mb_vld[i]; mb_vld in the ISSUE cycle SHALL be ignored; leave to WRITE the cycle after all N_BALLS bits are set.
REQ-022 A repeat mb_vld[i] pulse while sticky bit i is set SHALL overwrite the latched value (last wins).
REQ-023 Sum SHALL be the saturating unsigned 32-bit addition of all latched values; clamps at 32'hFFFF_FFFF.
REQ-024 WRITE: SHALL assert exactly one of w_en_top (row<ROWS/2) or w_en_btm for one cycle; din=12'hFFF if sum>=THRESH else 12'h000; every pixel SHALL be written.
REQ-025 w_addr SHALL equal ((row mod ROWS/2)*COLS+col)[9:0].
REQ-026 WRITE advance: col+1; at col=COLS-1 col wraps to 0 and row+1; at last pixel (col=COLS-1, row=ROWS-1) go to SWAP, else ISSUE.
REQ-027 SWAP: SHALL assert swap_en for exactly one cycle, then IDLE.
REQ-028 frame_go while busy=1 SHALL be dropped (not queued); frame_go in the SWAP cycle SHALL also be dropped.
REQ-029 Per-pixel latency SHALL be 1 (ISSUE) + W (WAIT cycles, W>=1) + 1 (WRITE).

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, col=row=0, sticky bits 0, latched values 0, ovr_cnt 0, and all outputs 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no swap_en; the first frame_go after release SHALL restart at pixel (0,0).

Configuration
REQ-032 Macro RENDER_SCHED_OVR_CNT_EN defined: ovr_cnt SHALL increment by 1 per dropped frame_go, saturating at 16'hFFFF.
REQ-033 Macro RENDER_SCHED_OVR_CNT_EN undefined: ovr_cnt SHALL be constant 0 with no counter logic; all other behaviour unchanged.

Verification
REQ-034 Defaults; reset; frame_go; balls answer 3 cycles after px_stb with 32'h0000_4000 each -> sum 32'h0000_8000, first write w_en_top=1, w_addr=0, din=12'hFFF.
REQ-035 Full frame with balls returning 0 -> 2048 writes (1024 top then 1024 bottom), all din=0, then one swap_en, busy falls the cycle after swap_en.
REQ-036 Ball 0 valid at WAIT cycle 1, ball 1 at cycle 5 -> WRITE only after cycle 5; pixel (31,0) -> w_addr=31; next p_y=32'h0000_8000, p_x=0.
REQ-037 mb_out 32'hFFFF_0000 on both balls -> sum saturates to 32'hFFFF_FFFF, din=12'hFFF.
REQ-038 Three frame_go pulses mid-frame with macro defined -> ovr_cnt=3, frame unaffected; macro undefined -> ovr_cnt=0.
REQ-039 rst_n low during WAIT at pixel (5,40) -> outputs 0 immediately, no swap_en; next frame_go -> px_stb with p_x=p_y=0.
